// File: rtl/king_pkg.sv
// Shared definitions for the king move generator: piece codes, FSM states,
// step direction table and host register indices.
package king_pkg;

  localparam int unsigned NUM_DIRS    = 8;
  localparam int unsigned BOARD_BYTES = 64;

  localparam logic signed [7:0] EMPTY = 8'sd0;
  localparam logic signed [7:0] WPAWN = 8'sd1;
  localparam logic signed [7:0] BPAWN = -8'sd1;
  localparam logic signed [7:0] WKING = 8'sd48;
  localparam logic signed [7:0] BKING = -8'sd48;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRead  = 3'd1;
  localparam logic [2:0] StScan  = 3'd2;
  localparam logic [2:0] StGen   = 3'd3;
  localparam logic [2:0] StWrite = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  // Order N, NE, E, SE, S, SW, W, NW; also the order boards are emitted in.
  localparam logic signed [5:0] DIR_OFFSET [NUM_DIRS] =
    '{6'sd8, 6'sd9, 6'sd1, -6'sd7, -6'sd8, -6'sd9, -6'sd1, 6'sd7};

  localparam logic [3:0] REG_CTRL  = 4'd0;
  localparam logic [3:0] REG_SRC   = 4'd1;
  localparam logic [3:0] REG_PIECE = 4'd2;
  localparam logic [3:0] REG_OUT   = 4'd3;

  function automatic logic dir_up(input logic [2:0] d);
    return (d == 3'd0) || (d == 3'd1) || (d == 3'd7);
  endfunction

  function automatic logic dir_down(input logic [2:0] d);
    return (d == 3'd3) || (d == 3'd4) || (d == 3'd5);
  endfunction

  function automatic logic dir_right(input logic [2:0] d);
    return (d == 3'd1) || (d == 3'd2) || (d == 3'd3);
  endfunction

  function automatic logic dir_left(input logic [2:0] d);
    return (d == 3'd5) || (d == 3'd6) || (d == 3'd7);
  endfunction

endpackage

// File: rtl/king_step_check.sv
// Combinational single-step check: target square and move validity.
// Define KING_CAPTURE_EN to accept opposite-colour targets as captures.
module king_step_check
  import king_pkg::*;
(
  input  logic [5:0]        square_i,
  input  logic [2:0]        dir_i,
  input  logic signed [7:0] target_byte_i,
  input  logic signed [7:0] piece_i,
  output logic [5:0]        target_o,
  output logic              valid_o
);

`ifdef KING_CAPTURE_EN
  localparam bit CaptureEn = 1'b1;
`else
  localparam bit CaptureEn = 1'b0;
`endif

  logic [2:0] rank;
  logic [2:0] file;
  logic       on_board;
  logic       opposite;

  assign rank = square_i[5:3];
  assign file = square_i[2:0];

  // Edge checks on rank/file so that e.g. E from file 7 cannot wrap to the next rank.
  assign on_board = !(dir_up(dir_i)    && rank == 3'd7) &&
                    !(dir_down(dir_i)  && rank == 3'd0) &&
                    !(dir_right(dir_i) && file == 3'd7) &&
                    !(dir_left(dir_i)  && file == 3'd0);

  assign target_o = square_i + $unsigned(DIR_OFFSET[dir_i]);
  assign opposite = (target_byte_i != EMPTY) && (target_byte_i[7] != piece_i[7]);
  assign valid_o  = on_board && ((target_byte_i == EMPTY) || (CaptureEn && opposite));

endmodule

// File: rtl/king_move_gen.sv
// Pseudo-legal king move generator: loads a board over Avalon-MM, writes one
// successor board per valid king step. Capture support via KING_CAPTURE_EN.
module king_move_gen
  import king_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  logic [2:0]        state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic [3:0]        count_q, count_d;
  logic [31:0]       src_base_q, src_base_d;
  logic [31:0]       out_base_q, out_base_d;
  logic signed [7:0] piece_q, piece_d;
  logic [5:0]        king_sq_q, king_sq_d;
  logic [2:0]        dir_q, dir_d;
  logic [5:0]        tgt_q, tgt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              mrd_q, mrd_d;
  logic              mwr_q, mwr_d;
  logic [31:0]       maddr_q, maddr_d;
  logic [7:0]        mwdata_q, mwdata_d;
  logic signed [7:0] board_q [BOARD_BYTES];

  logic [5:0]        step_tgt;
  logic              step_valid;
  logic [5:0]        wr_idx;
  logic signed [7:0] wr_byte;
  logic              rd_capture;
  logic              unused_rdata_hi;

  assign unused_rdata_hi = ^master_readdata[31:8];

  king_step_check u_step (
    .square_i      (king_sq_q),
    .dir_i         (dir_q),
    .target_byte_i (board_q[step_tgt]),
    .piece_i       (piece_q),
    .target_o      (step_tgt),
    .valid_o       (step_valid)
  );

  assign slave_waitrequest = (state_q != StIdle);
  assign master_address    = maddr_q;
  assign master_read       = mrd_q;
  assign master_write      = mwr_q;
  assign master_writedata  = {24'd0, mwdata_q};
  assign rd_capture        = (state_q == StRead) && master_readdatavalid && rd_pend_q;

  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      case (slave_address)
        REG_CTRL:  slave_readdata = {28'd0, count_q};
        REG_SRC:   slave_readdata = src_base_q;
        REG_PIECE: slave_readdata = {{24{piece_q[7]}}, piece_q};
        REG_OUT:   slave_readdata = out_base_q;
        default:   slave_readdata = '0;
      endcase
    end
  end

  // Byte to present next: once a write is accepted we move on to the following index.
  always_comb begin
    wr_idx  = mwr_q ? idx_q + 6'd1 : idx_q;
    wr_byte = board_q[wr_idx];
    if (wr_idx == king_sq_q) begin
      wr_byte = EMPTY;
    end else if (wr_idx == tgt_q) begin
      wr_byte = piece_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    src_base_d = src_base_q;
    out_base_d = out_base_q;
    piece_d    = piece_q;
    king_sq_d  = king_sq_q;
    dir_d      = dir_q;
    tgt_d      = tgt_q;
    rd_pend_d  = rd_pend_q;
    mrd_d      = mrd_q;
    mwr_d      = mwr_q;
    maddr_d    = maddr_q;
    mwdata_d   = mwdata_q;
    case (state_q)
      StIdle: begin
        if (slave_write) begin
          case (slave_address)
            REG_CTRL: begin
              state_d   = StRead;
              count_d   = '0;
              idx_d     = '0;
              rd_pend_d = 1'b0;
            end
            REG_SRC:   src_base_d = slave_writedata;
            REG_PIECE: piece_d    = slave_writedata[7:0];
            REG_OUT:   out_base_d = slave_writedata;
            default:   ;
          endcase
        end
      end
      StRead: begin
        if (rd_capture) begin
          rd_pend_d = 1'b0;
          idx_d     = idx_q + 6'd1;
          if (idx_q == 6'd63) state_d = StScan;
        end else if (mrd_q) begin
          if (!master_waitrequest) begin
            mrd_d     = 1'b0;
            rd_pend_d = 1'b1;
          end
        end else if (!rd_pend_q) begin
          mrd_d   = 1'b1;
          maddr_d = src_base_q + {26'd0, idx_q};
        end
      end
      StScan: begin
        if (board_q[idx_q] == piece_q) begin
          king_sq_d = idx_q;
          dir_d     = '0;
          state_d   = StGen;
        end else if (idx_q == 6'd63) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      StGen: begin
        if (step_valid) begin
          tgt_d   = step_tgt;
          idx_d   = '0;
          state_d = StWrite;
        end else if (dir_q == 3'd7) begin
          state_d = StDone;
        end else begin
          dir_d = dir_q + 3'd1;
        end
      end
      StWrite: begin
        if (!mwr_q || !master_waitrequest) begin
          if (mwr_q && idx_q == 6'd63) begin
            mwr_d   = 1'b0;
            count_d = count_q + 4'd1;
            if (dir_q == 3'd7) begin
              state_d = StDone;
            end else begin
              dir_d   = dir_q + 3'd1;
              state_d = StGen;
            end
          end else begin
            mwr_d    = 1'b1;
            maddr_d  = out_base_q + {22'd0, count_q, wr_idx};
            mwdata_d = wr_byte;
            if (mwr_q) idx_d = idx_q + 6'd1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      count_q    <= '0;
      src_base_q <= '0;
      out_base_q <= '0;
      piece_q    <= '0;
      king_sq_q  <= '0;
      dir_q      <= '0;
      tgt_q      <= '0;
      rd_pend_q  <= 1'b0;
      mrd_q      <= 1'b0;
      mwr_q      <= 1'b0;
      maddr_q    <= '0;
      mwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      src_base_q <= src_base_d;
      out_base_q <= out_base_d;
      piece_q    <= piece_d;
      king_sq_q  <= king_sq_d;
      dir_q      <= dir_d;
      tgt_q      <= tgt_d;
      rd_pend_q  <= rd_pend_d;
      mrd_q      <= mrd_d;
      mwr_q      <= mwr_d;
      maddr_q    <= maddr_d;
      mwdata_q   <= mwdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_capture) board_q[idx_q] <= master_readdata[7:0];
  end

endmodule

// File: tb/tb_king_move_gen.sv
// Bench for king_move_gen: directed board table plus random boards, checked
// against a rank/file reference model and a byte-level memory image.
module tb_king_move_gen;
  import king_pkg::*;

`ifdef KING_CAPTURE_EN
  localparam bit Cap = 1'b1;
`else
  localparam bit Cap = 1'b0;
`endif

  localparam int Src     = 256;
  localparam int Out     = 1024;
  localparam int MemSize = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slave_waitrequest;
  logic [3:0]  slave_address = '0;
  logic        slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = '0;
  logic        master_waitrequest = 1'b0;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata = '0;
  logic        master_readdatavalid = 1'b0;
  logic        master_write;
  logic [31:0] master_writedata;

  king_move_gen dut (
    .clk                  (clk),
    .rst                  (rst),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ksq; int kval; int psq; int pval; int qsq; int qval;
    int piece; int n_cap; int n_nocap; bit stall;
  } vec_t;

  vec_t vecs[8];
  byte  mem     [MemSize];
  byte  exp_mem [MemSize];
  int   dr[8]   = '{1, 1, 0, -1, -1, -1, 0, 1};
  int   df[8]   = '{0, 1, 1, 1, 0, -1, -1, -1};
  int   tgt0[8] = '{35, 36, 28, 20, 19, 18, 26, 34};
  int   total = 0;
  int   bad   = 0;
  bit   stall = 1'b0;
  bit   pend  = 1'b0;
  int   pdly, paddr, nwr, proto_err;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // One clock of the memory model, acting at the falling edge.
  task automatic tick();
    int wa;
    @(negedge clk);
    if (pend && pdly == 0) begin
      master_readdatavalid = 1'b1;
      master_readdata      = {24'($urandom()), 8'(mem[paddr])};
      pend                 = 1'b0;
    end else begin
      master_readdatavalid = 1'b0;
      if (pend) pdly--;
    end
    master_waitrequest = stall ? 1'($urandom_range(0, 1)) : 1'b0;
    if (master_read && master_write) proto_err++;
    if (master_read && !master_waitrequest) begin
      if (pend || master_address >= 32'(MemSize)) proto_err++;
      pend  = 1'b1;
      paddr = int'(master_address) % MemSize;
      pdly  = stall ? int'($urandom_range(0, 3)) : 0;
    end
    if (master_write && !master_waitrequest) begin
      nwr++;
      wa = int'(master_address);
      if (master_writedata[31:8] != 24'd0) proto_err++;
      if (wa >= Out && wa < Out + 9 * 64) mem[wa] = byte'(master_writedata[7:0]);
      else proto_err++;
    end
  endtask

  task automatic reg_write(input logic [3:0] a, input int d);
    slave_address   = a;
    slave_writedata = d;
    slave_write     = 1'b1;
    tick();
    slave_write = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a, output int d);
    slave_address = a;
    slave_read    = 1'b1;
    #1 d = int'(slave_readdata);
    tick();
    slave_read = 1'b0;
  endtask

  // Reference: lowest matching square, then 8 king steps by rank/file arithmetic.
  task automatic model(input int piece, output int n);
    int ks, r, f, t, v;
    ks = -1;
    for (int s = 0; s < 64; s++) if (ks < 0 && int'(mem[Src + s]) == piece) ks = s;
    exp_mem = mem;
    n = 0;
    if (ks >= 0) begin
      for (int d = 0; d < 8; d++) begin
        r = ks / 8 + dr[d];
        f = ks % 8 + df[d];
        if (r >= 0 && r < 8 && f >= 0 && f < 8) begin
          t = r * 8 + f;
          v = int'(mem[Src + t]);
          if (v == 0 || (Cap && ((v < 0) != (piece < 0)))) begin
            for (int i = 0; i < 64; i++)
              exp_mem[Out + n * 64 + i] = (i == ks) ? 8'sd0 :
                                          (i == t)  ? byte'(piece) : mem[Src + i];
            n++;
          end
        end
      end
    end
  endtask

  task automatic run(input int piece, input int want, input string tag);
    int n, got, cyc, wr_at_done, mism;
    model(piece, n);
    if (want < 0) want = n;
    nwr = 0;
    proto_err = 0;
    reg_write(REG_SRC, Src);
    reg_write(REG_PIECE, piece);
    reg_write(REG_OUT, Out);
    reg_write(REG_CTRL, 0);
    check({tag, " busy"}, int'(slave_waitrequest), 1);
    slave_address = REG_CTRL;
    slave_read    = 1'b1;
    cyc = 0;
    while (slave_waitrequest && cyc < 20000) begin
      tick();
      cyc++;
    end
    check({tag, " timeout"}, int'(slave_waitrequest), 0);
    wr_at_done = nwr;
    #1 got = int'(slave_readdata);
    tick();
    slave_read = 1'b0;
    check({tag, " count"}, got, want);
    check({tag, " writes"}, wr_at_done, want * 64);
    mism = 0;
    for (int i = 0; i < MemSize; i++) if (mem[i] != exp_mem[i]) mism++;
    check({tag, " mem"}, mism, 0);
    check({tag, " bus"}, proto_err, 0);
    reg_read(REG_PIECE, got);
    check({tag, " piece reg"}, got, piece);
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < MemSize; i++) mem[i] = 8'h55;
    for (int s = 0; s < 64; s++) mem[Src + s] = 0;
    mem[Src + v.ksq] = byte'(v.kval);
    if (v.psq >= 0) mem[Src + v.psq] = byte'(v.pval);
    if (v.qsq >= 0) mem[Src + v.qsq] = byte'(v.qval);
  endtask

  initial begin
    int rd, piece, a, v;
    vecs[0] = '{27, int'(WKING), -1, 0, -1, 0, int'(WKING), 8, 8, 1'b0};
    vecs[1] = '{0, int'(WKING), -1, 0, -1, 0, int'(WKING), 3, 3, 1'b0};
    vecs[2] = '{7, int'(WKING), -1, 0, -1, 0, int'(WKING), 3, 3, 1'b0};
    vecs[3] = '{27, int'(WKING), 35, int'(WPAWN), 36, int'(BPAWN), int'(WKING), 7, 6, 1'b0};
    vecs[4] = '{10, int'(BKING), -1, 0, -1, 0, int'(WKING), 0, 0, 1'b0};
    vecs[5] = '{63, int'(BKING), 62, int'(WPAWN), 55, int'(BPAWN), int'(BKING), 2, 1, 1'b0};
    vecs[6] = '{27, int'(WKING), 35, int'(WPAWN), 36, int'(BPAWN), int'(WKING), 7, 6, 1'b1};
    vecs[7] = '{27, int'(WKING), -1, 0, -1, 0, int'(WKING), 8, 8, 1'b1};

    repeat (3) tick();
    rst = 1'b0;
    check("rst waitreq", int'(slave_waitrequest), 0);
    check("rst mread", int'(master_read), 0);
    check("rst mwrite", int'(master_write), 0);
    check("rst maddr", int'(master_address), 0);
    check("rst mwdata", int'(master_writedata), 0);
    for (int r = 0; r < 4; r++) begin
      reg_read(4'(r), rd);
      check($sformatf("rst reg%0d", r), rd, 0);
    end

    for (int k = 0; k < 8; k++) begin
      stall = vecs[k].stall;
      load_vec(vecs[k]);
      run(vecs[k].piece, Cap ? vecs[k].n_cap : vecs[k].n_nocap, $sformatf("vec%0d", k));
      if (k == 0) begin
        for (int j = 0; j < 8; j++)
          check($sformatf("vec0 target%0d", j), int'(mem[Out + j * 64 + tgt0[j]]), 48);
      end
    end
    reg_read(4'd9, rd);
    check("unmapped read", rd, 0);
    reg_read(REG_SRC, rd);
    check("src reg", rd, Src);

    for (int k = 0; k < 6; k++) begin
      stall = 1'($urandom_range(0, 1));
      for (int i = 0; i < MemSize; i++) mem[i] = 8'h55;
      for (int s = 0; s < 64; s++) begin
        v = int'($urandom_range(1, 47));
        if ($urandom_range(0, 1) == 1) v = -v;
        mem[Src + s] = ($urandom_range(0, 1) == 1) ? 8'sd0 : byte'(v);
      end
      piece = ($urandom_range(0, 1) == 1) ? 48 : -48;
      a = int'($urandom_range(0, 63));
      if ($urandom_range(0, 5) != 0) mem[Src + a] = byte'(piece);
      if ($urandom_range(0, 1) == 1) mem[Src + int'($urandom_range(0, 63))] = byte'(piece);
      run(piece, -1, $sformatf("rand%0d", k));
    end

    // Abort mid-run with reset: everything returns to idle with cleared registers.
    stall = 1'b1;
    load_vec(vecs[0]);
    reg_write(REG_SRC, Src);
    reg_write(REG_PIECE, 48);
    reg_write(REG_OUT, Out);
    reg_write(REG_CTRL, 0);
    repeat (300) tick();
    check("abort busy", int'(slave_waitrequest), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pend = 1'b0;
    stall = 1'b0;
    check("abort waitreq", int'(slave_waitrequest), 0);
    check("abort mread", int'(master_read), 0);
    check("abort mwrite", int'(master_write), 0);
    reg_read(REG_SRC, rd);
    check("abort src reg", rd, 0);
    reg_read(REG_CTRL, rd);
    check("abort count", rd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
